// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state encoding for alu_seq_unit.
// Optional feature macro: ALU_ROTATE_EN (iterative rotl/rotr on opcodes 1000/1001).
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_SHL  = 4'b0010;
    localparam logic [OP_W-1:0] OP_SHR  = 4'b0011;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0100;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0101;
    localparam logic [OP_W-1:0] OP_NOT  = 4'b0110;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0111;
    localparam logic [OP_W-1:0] OP_ROTL = 4'b1000;
    localparam logic [OP_W-1:0] OP_ROTR = 4'b1001;
    localparam logic [OP_W-1:0] OP_NOP  = 4'b1111;

    localparam int unsigned FLG_W = 4;
    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shift/rotate engine with amount down-counter.
// Rotate mode is only ever requested when ALU_ROTATE_EN is defined in the top.
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned SHW = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [N-1:0] a,
    input  logic [SHW-1:0] amt,
    input  logic         left,
    input  logic         rot,
    output logic [N-1:0] step_val_c,
    output logic         step_carry_c,
    output logic         done_c
);

    logic [N-1:0]   sh_q;
    logic [SHW-1:0] cnt_q;
    logic           left_q;
    logic           rot_q;

    // Value and carry produced by the next single-bit step.
    always_comb begin
        step_val_c   = sh_q;
        step_carry_c = 1'b0;
        if (left_q) begin
            step_val_c   = {sh_q[N-2:0], rot_q ? sh_q[N-1] : 1'b0};
            step_carry_c = sh_q[N-1];
        end else begin
            step_val_c   = {rot_q ? sh_q[0] : 1'b0, sh_q[N-1:1]};
            step_carry_c = sh_q[0];
        end
    end

    // The step taken while the count is 1 is the final one.
    assign done_c = (cnt_q == SHW'(1));

    // Load operand and mode on accept, then shift and count down each step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            left_q <= 1'b0;
            rot_q  <= 1'b0;
        end else if (load) begin
            sh_q   <= a;
            cnt_q  <= amt;
            left_q <= left;
            rot_q  <= rot;
        end else if (step) begin
            sh_q  <= step_val_c;
            cnt_q <= cnt_q - SHW'(1);
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered ALU with valid/ready handshake and iterative shifts.
// Optional feature macro: ALU_ROTATE_EN enables iterative rotl (1000) / rotr (1001).
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic [3:0]   op_out,
    output logic         busy
);

    localparam int unsigned SHW = $clog2(N);

    state_t         state;
    logic [3:0]     op_q;

    logic [N:0]     sum_c;
    logic [N:0]     diff_c;
    logic [N-1:0]   alu_r_c;
    logic           alu_cy_c;
    logic           alu_ov_c;

    logic           accept_c;
    logic           is_iter_c;
    logic           left_c;
    logic           rot_c;
    logic [SHW-1:0] amt_c;
    logic           load_c;

    logic [N-1:0]   step_val_c;
    logic           step_carry_c;
    logic           done_c;

    function automatic logic [3:0] pack_flags(input logic [N-1:0] r, input logic cy, input logic ov);
        logic [3:0] f;
        f        = '0;
        f[FLG_N] = r[N-1];
        f[FLG_Z] = (r == '0);
        f[FLG_C] = cy;
        f[FLG_V] = ov;
        return f;
    endfunction

    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept_c = in_valid && in_ready;
    assign amt_c    = b[SHW-1:0];

    // Classify the requested opcode as iterative and pick its direction/mode.
    always_comb begin
        is_iter_c = (op == OP_SHL) || (op == OP_SHR);
        left_c    = (op == OP_SHL);
        rot_c     = 1'b0;
`ifdef ALU_ROTATE_EN
        if ((op == OP_ROTL) || (op == OP_ROTR)) begin
            is_iter_c = 1'b1;
            left_c    = (op == OP_ROTL);
            rot_c     = 1'b1;
        end
`endif
    end

    // Shift by zero skips the SHIFT state and completes like a plain op.
    assign load_c = accept_c && is_iter_c && (amt_c != '0);

    // Single-cycle result for every opcode; iterative ops with amount 0 pass A.
    always_comb begin
        sum_c    = {1'b0, a} + {1'b0, b};
        diff_c   = {1'b0, a} - {1'b0, b};
        alu_r_c  = a;
        alu_cy_c = 1'b0;
        alu_ov_c = 1'b0;
        case (op)
            OP_ADD: begin
                alu_r_c  = sum_c[N-1:0];
                alu_cy_c = sum_c[N];
                alu_ov_c = (a[N-1] == b[N-1]) && (sum_c[N-1] != a[N-1]);
            end
            OP_SUB: begin
                alu_r_c  = diff_c[N-1:0];
                alu_cy_c = diff_c[N];
                alu_ov_c = (a[N-1] != b[N-1]) && (diff_c[N-1] != a[N-1]);
            end
            OP_AND:  alu_r_c = a & b;
            OP_OR:   alu_r_c = a | b;
            OP_NOT:  alu_r_c = ~a;
            OP_XOR:  alu_r_c = a ^ b;
            default: alu_r_c = a;
        endcase
    end

    alu_shift_iter #(
        .N   (N),
        .SHW (SHW)
    ) u_shift (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load_c),
        .step         (state == ST_SHIFT),
        .a            (a),
        .amt          (amt_c),
        .left         (left_c),
        .rot          (rot_c),
        .step_val_c   (step_val_c),
        .step_carry_c (step_carry_c),
        .done_c       (done_c)
    );

    // Control FSM with registered result, flags, opcode and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_NOP;
            result    <= '0;
            flags     <= '0;
            op_out    <= OP_NOP;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (done_c) begin
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        result    <= step_val_c;
                        flags     <= pack_flags(step_val_c, step_carry_c, 1'b0);
                        op_out    <= op_q;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if ((state == ST_DONE) && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                    if (accept_c) begin
                        if (load_c) begin
                            state     <= ST_SHIFT;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                            op_q      <= op;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            result    <= alu_r_c;
                            flags     <= pack_flags(alu_r_c, alu_cy_c, alu_ov_c);
                            op_out    <= op;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit (N=8): vector table, corner sequences,
// and randomized transactions against an arithmetic reference model.
module tb_alu_seq_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] op = 4'hF;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic [3:0] flags;
    logic [3:0] op_out;
    logic       busy;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [3:0] f;
        int         lat;
        int         bz;
    } vec_t;

    vec_t vecs[$];

    alu_seq_unit #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .op_out    (op_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: result, flags and latency from the opcode rules alone.
    function automatic vec_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        vec_t   e;
        int     k;
        int     s;
        logic   c;
        logic   v;
        logic [7:0] r;
        logic [15:0] w;
        k = int'(y[2:0]);
        c = 1'b0;
        v = 1'b0;
        r = x;
        e.lat = 1;
        e.bz = 0;
        case (o)
            4'h0: begin
                s = int'(x) + int'(y);
                r = 8'(s);
                c = (s > 255);
                v = (x[7] == y[7]) && (r[7] != x[7]);
            end
            4'h1: begin
                r = x - y;
                c = (x < y);
                v = (x[7] != y[7]) && (r[7] != x[7]);
            end
            4'h2: begin
                r = x << k;
                c = (k != 0) ? x[8-k] : 1'b0;
                e.lat = k + 1;
                e.bz = k;
            end
            4'h3: begin
                r = x >> k;
                c = (k != 0) ? x[k-1] : 1'b0;
                e.lat = k + 1;
                e.bz = k;
            end
            4'h4: r = x & y;
            4'h5: r = x | y;
            4'h6: r = ~x;
            4'h7: r = x ^ y;
`ifdef ALU_ROTATE_EN
            4'h8: begin
                w = {x, x} << k;
                r = w[15:8];
                c = (k != 0) ? r[0] : 1'b0;
                e.lat = k + 1;
                e.bz = k;
            end
            4'h9: begin
                w = {x, x} >> k;
                r = w[7:0];
                c = (k != 0) ? r[7] : 1'b0;
                e.lat = k + 1;
                e.bz = k;
            end
`endif
            default: r = x;
        endcase
        e.op = o;
        e.a = x;
        e.b = y;
        e.r = r;
        e.f = {r[7], (r == 8'h00), c, v};
        return e;
    endfunction

    function automatic vec_t mk(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                input logic [7:0] r, input logic [3:0] f, input int lat, input int bz);
        vec_t e;
        e.op = o; e.a = x; e.b = y; e.r = r; e.f = f; e.lat = lat; e.bz = bz;
        return e;
    endfunction

    // One transaction from IDLE, entered and left at posedge+1 with out_ready=1.
    task automatic run_txn(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                           input logic scramble, output logic [7:0] r, output logic [3:0] f,
                           output logic [3:0] oo, output int lat, output int bz);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        bz = 0;
        while (!out_valid && lat < 64) begin
            bz += int'(busy);
            if (scramble) begin
                op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL timeout waiting for out_valid op=%0h", o);
        end
        r = result; f = flags; oo = op_out;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] r;
        logic [3:0] f;
        logic [3:0] oo;
        int lat;
        int bz;
        vec_t e;

        // Vector table from the opcode rules and the documented corner cases.
        vecs.push_back(mk(4'h0, 8'hFF, 8'h01, 8'h00, 4'b0110, 1, 0));
        vecs.push_back(mk(4'h1, 8'h80, 8'h01, 8'h7F, 4'b0001, 1, 0));
        vecs.push_back(mk(4'h1, 8'h01, 8'h02, 8'hFF, 4'b1010, 1, 0));
        vecs.push_back(mk(4'h2, 8'h81, 8'h03, 8'h08, 4'b0000, 4, 3));
        vecs.push_back(mk(4'h3, 8'h81, 8'h00, 8'h81, 4'b1000, 1, 0));
        vecs.push_back(mk(4'h0, 8'h7F, 8'h01, 8'h80, 4'b1001, 1, 0));
        vecs.push_back(mk(4'h4, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1, 0));
        vecs.push_back(mk(4'h6, 8'h0F, 8'h77, 8'hF0, 4'b1000, 1, 0));
        vecs.push_back(mk(4'h7, 8'hAA, 8'h55, 8'hFF, 4'b1000, 1, 0));
        vecs.push_back(mk(4'hF, 8'h5A, 8'h12, 8'h5A, 4'b0000, 1, 0));
        vecs.push_back(mk(4'hA, 8'h00, 8'h34, 8'h00, 4'b0100, 1, 0));
        vecs.push_back(mk(4'h3, 8'h80, 8'h07, 8'h01, 4'b0000, 8, 7));
        vecs.push_back(mk(4'h2, 8'hFF, 8'h07, 8'h80, 4'b1010, 8, 7));
`ifdef ALU_ROTATE_EN
        vecs.push_back(mk(4'h8, 8'h81, 8'h01, 8'h03, 4'b0010, 2, 1));
        vecs.push_back(mk(4'h9, 8'h01, 8'h01, 8'h80, 4'b1010, 2, 1));
`else
        vecs.push_back(mk(4'h8, 8'h81, 8'h01, 8'h81, 4'b1000, 1, 0));
        vecs.push_back(mk(4'h9, 8'h01, 8'h05, 8'h01, 4'b0000, 1, 0));
`endif

        // Reset state.
        #12;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst result", 32'(result), 32'h00);
        check("rst flags", 32'(flags), 32'h0);
        check("rst op_out", 32'(op_out), 32'hF);
        check("rst busy", 32'(busy), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst in_ready", 32'(in_ready), 32'd1);

        // Table-driven vectors; inputs scrambled while the unit works.
        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, r, f, oo, lat, bz);
            check($sformatf("vec%0d result", i), 32'(r), 32'(vecs[i].r));
            check($sformatf("vec%0d flags", i), 32'(f), 32'(vecs[i].f));
            check($sformatf("vec%0d op_out", i), 32'(oo), 32'(vecs[i].op));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d busy cycles", i), 32'(bz), 32'(vecs[i].bz));
            check($sformatf("vec%0d drained", i), 32'(out_valid), 32'd0);
        end

        // Back-pressure: result held stable, then back-to-back accept.
        out_ready = 1'b0;
        op = 4'h4; a = 8'hF0; b = 8'h3C; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
            check($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d result", i), 32'(result), 32'h30);
            check($sformatf("bp%0d flags", i), 32'(flags), 32'h0);
            check($sformatf("bp%0d op_out", i), 32'(op_out), 32'h4);
            check($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        op = 4'h5; a = 8'h0F; b = 8'hF0; in_valid = 1'b1;
        #1;
        check("b2b in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b out_valid", 32'(out_valid), 32'd1);
        check("b2b result", 32'(result), 32'hFF);
        check("b2b flags", 32'(flags), 32'h8);
        check("b2b op_out", 32'(op_out), 32'h5);
        @(posedge clk); #1;
        check("b2b drained", 32'(out_valid), 32'd0);

        // Reset in the middle of a shl by 7 aborts without a result.
        op = 4'h2; a = 8'h01; b = 8'h07; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midshift busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort result", 32'(result), 32'h00);
        check("abort op_out", 32'(op_out), 32'hF);
        check("abort busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("post-abort idle%0d", i), 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        run_txn(4'h0, 8'h12, 8'h34, 1'b0, r, f, oo, lat, bz);
        check("post-abort add result", 32'(r), 32'h46);
        check("post-abort add flags", 32'(f), 32'h0);
        check("post-abort add latency", 32'(lat), 32'd1);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 200; i++) begin
            e = model(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
            run_txn(e.op, e.a, e.b, 1'($urandom), r, f, oo, lat, bz);
            check($sformatf("rnd%0d op%0h result", i, e.op), 32'(r), 32'(e.r));
            check($sformatf("rnd%0d op%0h flags", i, e.op), 32'(f), 32'(e.f));
            check($sformatf("rnd%0d op%0h op_out", i, e.op), 32'(oo), 32'(e.op));
            check($sformatf("rnd%0d op%0h latency", i, e.op), 32'(lat), 32'(e.lat));
            check($sformatf("rnd%0d op%0h busy cycles", i, e.op), 32'(bz), 32'(e.bz));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
